// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for a non-pipelined core: walks FETCH..WRITEBACK,
// waits on memory ready signals with an optional timeout, and counts retired instructions.
module stage_sequencer #(
  parameter int IM_ADDR_W = 10,
  parameter int DM_ADDR_W = 12,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             im_ready,
  input  logic             dm_ready,
  input  logic             is_mem_op,
  input  logic             is_store,
  output logic             enable_fetch,
  output logic             enable_decode,
  output logic             enable_execute,
  output logic             enable_memaccess,
  output logic             enable_writeback,
  output logic             IM_read,
  output logic             DM_read,
  output logic             DM_write,
  output logic [2:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  // Address widths are carried for documentation only; reject nonsense values at elaboration.
  if (IM_ADDR_W < 1 || DM_ADDR_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("stage_sequencer: IM_ADDR_W, DM_ADDR_W and CNT_W must be positive");
  end

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMACCESS = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t            state_q;
  state_t            state_next;
  logic              store_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;

  // Handshake: a memory stage holds its strobe high every cycle until the matching
  // ready is sampled 1 at a rising edge; that edge completes the access.
  always_comb begin
    state_next = state_q;
    wait_inc   = 1'b0;
    case (state_q)
      S_IDLE:      state_next = halt_req ? S_HALT : S_FETCH;
      S_FETCH: begin
        if (im_ready)                          state_next = S_DECODE;
        else if (TO_EN && wait_cnt == TO_LAST) state_next = S_ERROR;
        else                                   wait_inc   = 1'b1;
      end
      S_DECODE:    state_next = S_EXECUTE;
      S_EXECUTE:   state_next = is_mem_op ? S_MEMACCESS : S_WRITEBACK;
      S_MEMACCESS: begin
        if (dm_ready)                          state_next = S_WRITEBACK;
        else if (TO_EN && wait_cnt == TO_LAST) state_next = S_ERROR;
        else                                   wait_inc   = 1'b1;
      end
      S_WRITEBACK: state_next = halt_req ? S_HALT : S_FETCH;
      S_HALT:      state_next = halt_req ? S_HALT : S_FETCH;
      S_ERROR:     state_next = S_ERROR;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      wait_cnt    <= '0;
      instr_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_next;
      if (state_q == S_EXECUTE) store_q <= is_store;
      // Any state change restarts the wait counter, so each FETCH/MEMACCESS visit starts at 0.
      if (state_next != state_q) wait_cnt <= '0;
      else if (wait_inc)         wait_cnt <= wait_cnt + 1'b1;
      if (state_q == S_WRITEBACK) instr_count <= instr_count + 1'b1;
      if (state_next == S_ERROR)  timeout_err <= 1'b1;
    end
  end

  // Moore decode only: outputs depend on state_q and store_q, never on inputs.
  always_comb begin
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_memaccess = 1'b0;
    enable_writeback = 1'b0;
    IM_read          = 1'b0;
    DM_read          = 1'b0;
    DM_write         = 1'b0;
    case (state_q)
      S_FETCH: begin
        enable_fetch = 1'b1;
        IM_read      = 1'b1;
      end
      S_DECODE:    enable_decode = 1'b1;
      S_EXECUTE:   enable_execute = 1'b1;
      S_MEMACCESS: begin
        enable_memaccess = 1'b1;
        DM_write         = store_q;
        DM_read          = !store_q;
      end
      S_WRITEBACK: enable_writeback = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-instruction expected state traces built from the
// stage rules, replayed cycle by cycle against the DUT, plus table vectors and corner sequences.
module tb_stage_sequencer;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERROR = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt_req = 1'b0, im_ready = 1'b0, dm_ready = 1'b0, is_mem_op = 1'b0, is_store = 1'b0;
  logic enable_fetch, enable_decode, enable_execute, enable_memaccess, enable_writeback;
  logic IM_read, DM_read, DM_write, timeout_err;
  logic [2:0] state;
  logic [CNT_W-1:0] instr_count;
  logic [7:0] outs;

  stage_sequencer #(.IM_ADDR_W(10), .DM_ADDR_W(12), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .im_ready(im_ready), .dm_ready(dm_ready),
    .is_mem_op(is_mem_op), .is_store(is_store),
    .enable_fetch(enable_fetch), .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_memaccess(enable_memaccess), .enable_writeback(enable_writeback),
    .IM_read(IM_read), .DM_read(DM_read), .DM_write(DM_write),
    .state(state), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  assign outs = {enable_fetch, enable_decode, enable_execute, enable_memaccess,
                 enable_writeback, IM_read, DM_read, DM_write};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int model_cnt = 0;
  int active_cyc, rd_cyc, wr_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'(S_IDLE));
    check({tag, "_outs"}, 32'(outs), 32'd0);
    check({tag, "_count"}, 32'(instr_count), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset(input logic h);
    rst = 1'b0; halt_req = h; im_ready = 1'b0; dm_ready = 1'b0; is_mem_op = 1'b0; is_store = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    model_cnt = 0;
    rst = 1'b1;
  endtask

  // ---------------- reference model: expected trace ----------------
  typedef struct { logic im_r; logic dm_r; logic mem; logic sto; logic halt; logic sq; } cyc_t;
  cyc_t       cyc_q[$];
  logic [2:0] exp_q[$];

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push_cyc(input logic [2:0] st, input logic im_r, input logic dm_r,
                                   input logic mem, input logic sto, input logic halt,
                                   input logic sq);
    cyc_t c;
    c.im_r = im_r; c.dm_r = dm_r; c.mem = mem; c.sto = sto; c.halt = halt; c.sq = sq;
    cyc_q.push_back(c);
    exp_q.push_back(st);
  endfunction

  // One instruction: fw extra fetch waits, dw extra data waits. Inputs that the rules
  // say are ignored in a given stage are randomised to prove they are ignored.
  function automatic void push_instr(input logic mem, input logic sto, input int fw,
                                     input int dw, input logic h);
    for (int k = 0; k <= fw; k++) push_cyc(S_FETCH, (k == fw), rb(), rb(), rb(), rb(), 1'b0);
    push_cyc(S_DECODE, rb(), rb(), rb(), rb(), rb(), 1'b0);
    push_cyc(S_EXECUTE, rb(), rb(), mem, sto, rb(), 1'b0);
    if (mem) for (int k = 0; k <= dw; k++) push_cyc(S_MEM, rb(), (k == dw), rb(), rb(), rb(), sto);
    push_cyc(S_WB, rb(), rb(), rb(), rb(), h, 1'b0);
  endfunction

  function automatic void push_halt(input int n);
    for (int k = 0; k < n; k++) push_cyc(S_HALT, rb(), rb(), rb(), rb(), 1'b1, 1'b0);
    push_cyc(S_HALT, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
  endfunction

  function automatic logic [7:0] exp_outs(input logic [2:0] st, input logic sq);
    logic [7:0] o;
    o = '0;
    case (st)
      S_FETCH:   begin o[7] = 1'b1; o[2] = 1'b1; end
      S_DECODE:  o[6] = 1'b1;
      S_EXECUTE: o[5] = 1'b1;
      S_MEM:     begin o[4] = 1'b1; o[1] = !sq; o[0] = sq; end
      S_WB:      o[3] = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic run_queue();
    cyc_t c;
    logic [2:0] es;
    while (exp_q.size() > 0) begin
      c  = cyc_q.pop_front();
      es = exp_q.pop_front();
      check("state", 32'(state), 32'(es));
      check("outs", 32'(outs), 32'(exp_outs(es, c.sq)));
      check("instr_count", 32'(instr_count), 32'(model_cnt));
      check("timeout_err", 32'(timeout_err), 32'(es == S_ERROR));
      if (state inside {[S_FETCH:S_WB]}) active_cyc++;
      if (DM_read)  rd_cyc++;
      if (DM_write) wr_cyc++;
      im_ready = c.im_r; dm_ready = c.dm_r; is_mem_op = c.mem; is_store = c.sto; halt_req = c.halt;
      if (es == S_WB) model_cnt = (model_cnt + 1) % (1 << CNT_W);
      @(posedge clk); #1;
    end
  endtask

  function automatic void clr_meas();
    active_cyc = 0; rd_cyc = 0; wr_cyc = 0;
  endfunction

  typedef struct { logic mem; logic sto; int fw; int dw; int len; int rd; int wr; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{mem: 1'b0, sto: 1'b0, fw: 0,  dw: 0,  len: 4,  rd: 0, wr: 0};
    vecs[1] = '{mem: 1'b1, sto: 1'b0, fw: 0,  dw: 0,  len: 5,  rd: 1, wr: 0};
    vecs[2] = '{mem: 1'b1, sto: 1'b0, fw: 0,  dw: 3,  len: 8,  rd: 4, wr: 0};
    vecs[3] = '{mem: 1'b1, sto: 1'b1, fw: 0,  dw: 2,  len: 7,  rd: 0, wr: 3};
    vecs[4] = '{mem: 1'b0, sto: 1'b0, fw: 3,  dw: 0,  len: 7,  rd: 0, wr: 0};
    vecs[5] = '{mem: 1'b1, sto: 1'b1, fw: 14, dw: 14, len: 33, rd: 0, wr: 15};
    vecs[6] = '{mem: 1'b0, sto: 1'b0, fw: 14, dw: 0,  len: 18, rd: 0, wr: 0};
    vecs[7] = '{mem: 1'b0, sto: 1'b1, fw: 0,  dw: 0,  len: 4,  rd: 0, wr: 0};

    #2;
    check_all_zero("por");

    // Three zero-wait ALU instructions: 1,2,3,5 x3 and count 3 after 12 cycles.
    do_reset(1'b0);
    push_cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_instr(1'b0, 1'b0, 0, 0, 1'b0);
    clr_meas();
    run_queue();
    check("alu3_cycles", 32'(active_cyc), 32'd12);
    check("alu3_count", 32'(instr_count), 32'd3);

    // Table vectors: latency and strobe-cycle counts per instruction shape.
    foreach (vecs[i]) begin
      push_instr(vecs[i].mem, vecs[i].sto, vecs[i].fw, vecs[i].dw, 1'b0);
      clr_meas();
      run_queue();
      check($sformatf("vec%0d_len", i), 32'(active_cyc), 32'(vecs[i].len));
      check($sformatf("vec%0d_rd", i), 32'(rd_cyc), 32'(vecs[i].rd));
      check($sformatf("vec%0d_wr", i), 32'(wr_cyc), 32'(vecs[i].wr));
    end

    // Halt requested mid-instruction: completes, parks in HALT, refetches after release.
    push_instr(1'b1, 1'b0, 1, 1, 1'b1);
    push_halt(3);
    push_instr(1'b0, 1'b0, 0, 0, 1'b0);
    run_queue();

    // Halt held through reset release: IDLE goes straight to HALT.
    do_reset(1'b1);
    push_cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_halt(2);
    push_instr(1'b1, 1'b1, 0, 0, 1'b0);
    run_queue();

    // Random instruction stream with occasional halts.
    for (int i = 0; i < 40; i++) begin
      logic h;
      h = ($urandom_range(0, 9) == 0);
      push_instr(rb(), rb(), $urandom_range(0, 5), $urandom_range(0, 5), h);
      if (h) push_halt($urandom_range(0, 3));
    end
    run_queue();

    // Counter wrap with CNT_W=4.
    do_reset(1'b0);
    push_cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push_instr(rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    run_queue();
    check("wrap_count", 32'(instr_count), 32'd0);

    // Fetch timeout: 15 not-ready cycles, then ERROR ignores halt_req and readies.
    do_reset(1'b0);
    push_cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) push_cyc(S_FETCH, 1'b0, rb(), rb(), rb(), rb(), 1'b0);
    for (int k = 0; k < 4; k++) push_cyc(S_ERROR, rb(), rb(), rb(), rb(), rb(), 1'b0);
    run_queue();

    // Data-memory timeout on a load.
    do_reset(1'b0);
    push_cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(S_EXECUTE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) push_cyc(S_MEM, rb(), 1'b0, rb(), rb(), rb(), 1'b0);
    for (int k = 0; k < 3; k++) push_cyc(S_ERROR, rb(), rb(), rb(), rb(), rb(), 1'b0);
    run_queue();

    // Asynchronous reset in the middle of a store's MEMACCESS.
    do_reset(1'b0);
    push_cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_cyc(S_EXECUTE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_cyc(S_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_queue();
    check("pre_rst_state", 32'(state), 32'(S_MEM));
    check("pre_rst_outs", 32'(outs), 32'(exp_outs(S_MEM, 1'b1)));
    #2 rst = 1'b0;
    #1;
    check_all_zero("mid_mem_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter IM_ADDR_W, default 10, the instruction-memory address width carried by the core, used only for documentation and bench alignment.
REQ-002 The block SHALL have parameter DM_ADDR_W, default 12, the data-memory address width, used only for documentation and bench alignment.
REQ-003 The block SHALL have parameter CNT_W, default 16, the width of the retired-instruction counter.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, the maximum consecutive not-ready wait cycles; a value of 0 disables the timeout.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- halt_req  in  1  request to stop at the next instruction boundary
- im_ready  in  1  instruction memory has returned the fetched word
- dm_ready  in  1  data memory has completed the access
- is_mem_op  in  1  decoded instruction is a load or store, valid in EXECUTE
- is_store  in  1  decoded memory op is a store, valid in EXECUTE
- enable_fetch  out  1  FETCH stage enable
- enable_decode  out  1  DECODE stage enable
- enable_execute  out  1  EXECUTE stage enable, also the PC update strobe
- enable_memaccess  out  1  MEMACCESS stage enable
- enable_writeback  out  1  WRITEBACK stage enable
- IM_read  out  1  instruction-memory read strobe
- DM_read  out  1  data-memory read strobe
- DM_write  out  1  data-memory write strobe
- state  out  3  current state encoding
- timeout_err  out  1  sticky memory-timeout flag
- instr_count  out  CNT_W  retired-instruction count

Function
REQ-007 State encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMACCESS=4, WRITEBACK=5, HALT=6, ERROR=7.
REQ-008 All enables and strobes SHALL be Moore outputs decoded from the state register and store_q, with no combinational path from any input to any output.
REQ-009 Exactly one enable_* SHALL be 1 in FETCH, DECODE, EXECUTE, MEMACCESS and WRITEBACK, and every enable_* SHALL be 0 in IDLE, HALT and ERROR.
REQ-010 IDLE SHALL transition next cycle to HALT if halt_req=1, else to FETCH.
REQ-011 In FETCH the block SHALL assert enable_fetch=1 and IM_read=1, stay in FETCH while im_ready=0, and move to DECODE on the cycle im_ready=1.
REQ-012 DECODE SHALL last exactly 1 cycle and then go to EXECUTE.
REQ-013 EXECUTE SHALL last exactly 1 cycle, latch store_q<=is_store, and go to MEMACCESS if is_mem_op=1, else to WRITEBACK.
REQ-014 In MEMACCESS the block SHALL assert DM_write=store_q and DM_read=!store_q, stay while dm_ready=0, and move to WRITEBACK on dm_ready=1.
REQ-015 WRITEBACK SHALL last 1 cycle, increment instr_count by 1 modulo 2^CNT_W (all-ones wraps to 0), and then go to HALT if halt_req=1, else to FETCH.
REQ-016 halt_req SHALL be sampled only in IDLE, WRITEBACK and HALT, so an instruction in flight always completes.
REQ-017 HALT SHALL return to FETCH on the first cycle halt_req=0.
REQ-018 Minimum instruction latency with zero-wait memories SHALL be 4 cycles for a non-memory instruction and 5 cycles for a memory instruction (FETCH to WRITEBACK inclusive).
REQ-019 wait_cnt SHALL clear on entry to FETCH or MEMACCESS and increment on each cycle spent in that state with its ready input equal to 0.
REQ-020 When TIMEOUT>0 and, in FETCH or MEMACCESS, the ready input is 0 while wait_cnt==TIMEOUT-1, the block SHALL go to ERROR and set timeout_err=1.
REQ-021 Ready=1 on the timeout cycle SHALL take priority over the timeout, giving a normal advance.
REQ-022 ERROR SHALL be terminal until reset, and timeout_err SHALL remain 1 until reset.
REQ-023 halt_req in ERROR SHALL have no effect.

Reset
REQ-024 On rst=0 the block SHALL asynchronously force state=IDLE, store_q=0, wait_cnt=0, instr_count=0 and timeout_err=0, with all enables and strobes 0.
REQ-025 Reset asserted mid-FETCH or mid-MEMACCESS SHALL drop IM_read, DM_read and DM_write in the same cycle, with no pending access retained.
REQ-026 After rst rises, the first FETCH SHALL occur 1 cycle later (IDLE then FETCH) when halt_req=0.

Verification
REQ-027 Bench scenario: im_ready=dm_ready=1, is_mem_op=0 for 3 instructions -> state sequence 1,2,3,5 repeated, and instr_count=3 after 12 cycles.
REQ-028 Bench scenario: load with dm_ready delayed 3 cycles -> DM_read=1 for 4 cycles, DM_write=0, and WRITEBACK on cycle 8 after FETCH.
REQ-029 Bench scenario: store with is_store=1 -> DM_write=1 and DM_read=0 throughout MEMACCESS.
REQ-030 Bench scenario: TIMEOUT=15 with im_ready held 0 -> state=7 and timeout_err=1 after 15 FETCH cycles; ready=1 on exactly the 15th cycle -> DECODE instead of ERROR.
REQ-031 Bench scenario: halt_req=1 raised during EXECUTE -> the instruction completes, state=6 after WRITEBACK, and FETCH occurs 1 cycle after halt_req falls.
REQ-032 Bench scenario: CNT_W=4 with 16 instructions -> instr_count wraps to 0; rst=0 asserted mid-MEMACCESS -> all outputs 0 and state=0 immediately.
